// File: rtl/sync_sel_gen.sv
// Sync pulse generator: qualifies ext 1PPS / internal period / software source
// and emits a delayed fixed-width pulse. Optional counters: SYNC_SEL_GEN_CNT_EN.
module sync_sel_gen #(
  parameter int unsigned PERIOD      = 16777216,
  parameter int unsigned PULSE_LEN   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        user_clk,
  input  logic        user_rst_n,
  input  logic [31:0] sync_sel,
  input  logic        ext_sync,
  output logic        sync_out,
  output logic        armed,
  output logic        busy
`ifdef SYNC_SEL_GEN_CNT_EN
  ,
  output logic [31:0] sync_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam int unsigned PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CW-1:0] INT_LAST = CW'(PERIOD - 1);
  localparam logic [PW-1:0] PLS_LAST = PW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DELAY = 2'd2,
    S_PULSE = 2'd3
  } state_t;

  logic [1:0]  src;
  logic        arm_bit;
  logic        cont;
  logic [15:0] dly_cfg;
  logic        unused_sel;

  assign src        = sync_sel[1:0];
  assign arm_bit    = sync_sel[4];
  assign cont       = sync_sel[5];
  assign dly_cfg    = sync_sel[31:16];
  assign unused_sel = ^{sync_sel[15:6], sync_sel[3:2]};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_last_q;
  logic                   ext_evt_q;
  logic [CW-1:0]          int_cnt_q, int_cnt_d;
  logic [1:0]             src_q;
  logic                   arm_q;
  logic [15:0]            dly_q, dly_d;
  logic [PW-1:0]          pls_q, pls_d;
  logic                   sync_out_q, armed_q, busy_q;

  logic int_evt;
  logic arm_rise;
  logic sel_evt;
  logic ext_src;

  assign int_evt  = (int_cnt_q == INT_LAST);
  assign arm_rise = arm_bit & ~arm_q;
  assign ext_src  = (src == 2'd1) || (src == 2'd2);

  always_comb begin
    sel_evt = 1'b0;
    case (src)
      2'd1:    sel_evt = ext_evt_q;
      2'd2:    sel_evt = int_evt;
      2'd3:    sel_evt = 1'b1;
      default: sel_evt = 1'b0;
    endcase
  end

  // The internal phase restarts whenever the source selection is rewritten.
  always_comb begin
    if (src_q != src) begin
      int_cnt_d = '0;
    end else if (int_evt) begin
      int_cnt_d = '0;
    end else begin
      int_cnt_d = int_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    pls_d   = pls_q;
    case (state_q)
      S_IDLE: begin
        if (arm_rise && (src != 2'd0)) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (sel_evt) begin
          dly_d = dly_cfg;
          if (dly_cfg == 16'd0) begin
            state_d = S_PULSE;
            pls_d   = PLS_LAST;
          end else begin
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        if (dly_q == 16'd1) begin
          state_d = S_PULSE;
          pls_d   = PLS_LAST;
        end else begin
          dly_d = dly_q - 16'd1;
        end
      end
      S_PULSE: begin
        if (pls_q == '0) begin
          state_d = (cont && ext_src) ? S_ARMED : S_IDLE;
        end else begin
          pls_d = pls_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Writing src=0 aborts from any state, truncating a pulse in flight.
    if (src == 2'd0) state_d = S_IDLE;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      ext_last_q <= 1'b0;
      ext_evt_q  <= 1'b0;
      int_cnt_q  <= '0;
      src_q      <= 2'd0;
      arm_q      <= 1'b1;
      dly_q      <= 16'd0;
      pls_q      <= '0;
      sync_out_q <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ext_sync};
      ext_last_q <= sync_q[SYNC_STAGES-1];
      ext_evt_q  <= sync_q[SYNC_STAGES-1] & ~ext_last_q;
      int_cnt_q  <= int_cnt_d;
      src_q      <= src;
      arm_q      <= arm_bit;
      dly_q      <= dly_d;
      pls_q      <= pls_d;
      sync_out_q <= (state_d == S_PULSE);
      armed_q    <= (state_d == S_ARMED);
      busy_q     <= (state_d == S_DELAY) || (state_d == S_PULSE);
    end
  end

  assign sync_out = sync_out_q;
  assign armed    = armed_q;
  assign busy     = busy_q;

`ifdef SYNC_SEL_GEN_CNT_EN
  logic [31:0] sync_cnt_q;
  logic [15:0] miss_cnt_q;
  logic        arm_acc;
  logic        miss_evt;

  assign arm_acc  = (state_q == S_IDLE) && arm_rise && (src != 2'd0);
  assign miss_evt = sel_evt && ext_src &&
                    ((state_q == S_DELAY) || (state_q == S_PULSE));

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      sync_cnt_q <= 32'd0;
      miss_cnt_q <= 16'd0;
    end else if (arm_acc) begin
      sync_cnt_q <= 32'd0;
      miss_cnt_q <= 16'd0;
    end else begin
      if ((state_d == S_PULSE) && !sync_out_q) sync_cnt_q <= sync_cnt_q + 32'd1;
      if (miss_evt && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign sync_cnt = sync_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_sync_sel_gen.sv
// Self-checking bench for sync_sel_gen: directed scenarios plus randomized
// scenarios checked against an interval-level model of the sync pulse timing.
module tb_sync_sel_gen;

  localparam int PERIOD = 16;
  localparam int PLEN   = 4;
  localparam int SS     = 2;

  logic        user_clk   = 1'b0;
  logic        user_rst_n = 1'b0;
  logic [31:0] sync_sel   = 32'h0;
  logic        ext_sync   = 1'b0;
  logic        sync_out, armed, busy;
`ifdef SYNC_SEL_GEN_CNT_EN
  logic [31:0] sync_cnt;
  logic [15:0] miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 user_clk = ~user_clk;

  sync_sel_gen #(
    .PERIOD     (PERIOD),
    .PULSE_LEN  (PLEN),
    .SYNC_STAGES(SS)
  ) dut (
    .user_clk  (user_clk),
    .user_rst_n(user_rst_n),
    .sync_sel  (sync_sel),
    .ext_sync  (ext_sync),
    .sync_out  (sync_out),
    .armed     (armed),
    .busy      (busy)
`ifdef SYNC_SEL_GEN_CNT_EN
    ,
    .sync_cnt  (sync_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  function automatic logic [31:0] word(input int src, input bit arm, input bit cont, input int d);
    logic [31:0] w;
    w        = '0;
    w[1:0]   = src[1:0];
    w[4]     = arm;
    w[5]     = cont;
    w[31:16] = d[15:0];
    return w;
  endfunction

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic go_idle();
    sync_sel = 32'h0;
    ext_sync = 1'b0;
    repeat (SS + 3) step();
  endtask

  task automatic test_reset();
    user_rst_n = 1'b0;
    sync_sel   = 32'h0000_0011;
    repeat (3) step();
    n_checks++;
    if ({sync_out, armed, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs actual=%b expected=000", {sync_out, armed, busy});
    end
    user_rst_n = 1'b1;
    repeat (4) step();
    n_checks++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_arm_held actual=%b expected=0", armed);
    end
    sync_sel = 32'h0000_0001;
    step();
    sync_sel = 32'h0000_0011;
    step();
    n_checks++;
    if (armed !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_arm_rise actual=%b expected=1", armed);
    end
    go_idle();
    n_checks++;
    if (armed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_src0_idle actual=%b expected=0", armed);
    end
  endtask

  task automatic test_ext_oneshot();
    bit eo, ea;
    sync_sel = word(1, 0, 0, 0);
    step();
    sync_sel = word(1, 1, 0, 0);
    step();
    ext_sync = 1'b1;
    for (int k = 0; k < 12; k++) begin
      eo = (k >= SS + 2) && (k <= SS + 1 + PLEN);
      ea = (k < SS + 2);
      n_checks++;
      if (sync_out !== eo) begin
        n_fail++;
        $display("FAIL ext_sync_out cyc=%0d actual=%b expected=%b", k, sync_out, eo);
      end
      n_checks++;
      if (armed !== ea || busy !== eo) begin
        n_fail++;
        $display("FAIL ext_armed_busy cyc=%0d actual=%b%b expected=%b%b", k, armed, busy, ea, eo);
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_int_cont();
    bit eo, eb, ea;
    for (int k = 0; k < 70; k++) begin
      sync_sel = word(2, k != 0, 1, 3);
      eo = (k >= 20) && (((k - 20) % PERIOD) < PLEN);
      eb = (k >= 17) && (((k - 17) % PERIOD) < 3 + PLEN);
      ea = (k >= 2) && !eb;
      n_checks++;
      if (sync_out !== eo) begin
        n_fail++;
        $display("FAIL int_sync_out cyc=%0d actual=%b expected=%b", k, sync_out, eo);
      end
      n_checks++;
      if (armed !== ea || busy !== eb) begin
        n_fail++;
        $display("FAIL int_armed_busy cyc=%0d actual=%b%b expected=%b%b", k, armed, busy, ea, eb);
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_sw_oneshot();
    bit eo;
    sync_sel = word(3, 0, 0, 5);
    step();
    sync_sel = word(3, 1, 0, 5);
    for (int j = 0; j < 40; j++) begin
      eo = (j >= 7) && (j <= 6 + PLEN);
      n_checks++;
      if (sync_out !== eo) begin
        n_fail++;
        $display("FAIL sw_sync_out cyc=%0d actual=%b expected=%b", j, sync_out, eo);
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_abort();
    sync_sel = word(3, 0, 0, 20);
    step();
    sync_sel = word(3, 1, 0, 20);
    for (int j = 0; j < 36; j++) begin
      if (j == 5) sync_sel = word(0, 1, 0, 20);
      if (j == 4) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL abort_pre_busy actual=%b expected=1", busy);
        end
      end
      if (j == 6) begin
        n_checks++;
        if (busy !== 1'b0 || armed !== 1'b0) begin
          n_fail++;
          $display("FAIL abort_idle actual=%b%b expected=00", busy, armed);
        end
      end
      n_checks++;
      if (sync_out !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_sync_out cyc=%0d actual=%b expected=0", j, sync_out);
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_latch_src_change();
    bit eo;
    sync_sel = word(3, 0, 0, 10);
    step();
    sync_sel = word(3, 1, 0, 10);
    for (int j = 0; j < 31; j++) begin
      if (j == 4) sync_sel = word(2, 1, 1, 2);
      eo = ((j >= 12) && (j <= 11 + PLEN)) || ((j >= 23) && (j <= 22 + PLEN));
      n_checks++;
      if (sync_out !== eo) begin
        n_fail++;
        $display("FAIL latch_sync_out cyc=%0d actual=%b expected=%b", j, sync_out, eo);
      end
      if (j == 16) begin
        n_checks++;
        if (armed !== 1'b1) begin
          n_fail++;
          $display("FAIL latch_rearm actual=%b expected=1", armed);
        end
      end
      step();
    end
    go_idle();
  endtask

  task automatic test_max_delay();
    int first;
    first = -1;
    sync_sel = word(3, 0, 0, 16'hFFFF);
    step();
    sync_sel = word(3, 1, 0, 16'hFFFF);
    for (int j = 0; j < 65546; j++) begin
      if (sync_out === 1'b1 && first < 0) first = j;
      if (j == 1000) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL maxdly_busy actual=%b expected=1", busy);
        end
      end
      step();
    end
    n_checks++;
    if (first != 65537) begin
      n_fail++;
      $display("FAIL maxdly_rise actual=%0d expected=65537", first);
    end
    go_idle();
  endtask

  task automatic test_random(input int iters);
    localparam int W = 80;
    bit ev[W], ext_hi[W], e_out[W], e_arm[W], e_busy[W];
    int src, d, t, w, nxt, e;
    bit cont;
    for (int it = 0; it < iters; it++) begin
      src  = $urandom_range(1, 3);
      d    = $urandom_range(0, 12);
      cont = 1'($urandom_range(0, 1));
      for (int k = 0; k < W; k++) begin
        ev[k] = 0; ext_hi[k] = 0; e_out[k] = 0; e_arm[k] = 0; e_busy[k] = 0;
      end
      t = $urandom_range(0, 6);
      while (t < W - 2) begin
        w = $urandom_range(2, 6);
        for (int k = t; k < t + w && k < W; k++) ext_hi[k] = 1;
        if (src == 1 && t + SS + 1 < W) ev[t + SS + 1] = 1;
        t = t + w + $urandom_range(2, 20);
      end
      if (src == 2) for (int k = PERIOD; k < W; k += PERIOD) ev[k] = 1;
      if (src == 3) for (int k = 0; k < W; k++) ev[k] = 1;
      // Armed intervals run from arming to the taken event; busy covers delay + pulse.
      nxt = 2;
      while (nxt < W) begin
        e = -1;
        for (int k = nxt; k < W; k++) if (ev[k]) begin e = k; break; end
        if (e < 0) begin
          for (int k = nxt; k < W; k++) e_arm[k] = 1;
          break;
        end
        for (int k = nxt; k <= e; k++) e_arm[k] = 1;
        for (int k = e + 1; k <= e + d + PLEN && k < W; k++) begin
          e_busy[k] = 1;
          if (k > e + d) e_out[k] = 1;
        end
        if (cont && src != 3) nxt = e + d + PLEN + 1;
        else break;
      end
      for (int k = 0; k < W; k++) begin
        sync_sel = word(src, k != 0, cont, d);
        ext_sync = ext_hi[k];
        n_checks++;
        if ({sync_out, armed, busy} !== {e_out[k], e_arm[k], e_busy[k]}) begin
          n_fail++;
          $display("FAIL rand_outputs it=%0d src=%0d d=%0d cont=%0b cyc=%0d actual=%b expected=%b",
                   it, src, d, cont, k, {sync_out, armed, busy}, {e_out[k], e_arm[k], e_busy[k]});
        end
        step();
      end
      sync_sel = 32'h0;
      ext_sync = 1'b0;
      step();
      n_checks++;
      if ({sync_out, armed, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL rand_src0_abort it=%0d actual=%b expected=000", it, {sync_out, armed, busy});
      end
      go_idle();
    end
  endtask

`ifdef SYNC_SEL_GEN_CNT_EN
  task automatic test_counters();
    sync_sel = word(1, 0, 1, 100);
    step();
    sync_sel = word(1, 1, 1, 100);
    step();
    n_checks++;
    if (sync_cnt !== 32'd0 || miss_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL cnt_clear actual=%0d/%0d expected=0/0", sync_cnt, miss_cnt);
    end
    for (int k = 0; k < 116; k++) begin
      ext_sync = (k < 3) || (k >= 50 && k < 53);
      step();
    end
    n_checks++;
    if (sync_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL cnt_sync actual=%0d expected=1", sync_cnt);
    end
    n_checks++;
    if (miss_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL cnt_miss actual=%0d expected=1", miss_cnt);
    end
    go_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_ext_oneshot();
    test_int_cont();
    test_sw_oneshot();
    test_abort();
    test_latch_src_change();
    test_random(10);
`ifdef SYNC_SEL_GEN_CNT_EN
    test_counters();
`endif
    test_max_delay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_sel_gen.md
Name: sync_sel_gen

Overview:
- Downstream consumer of the software-written 32-bit sync-select register value (user_clk domain).
- Decodes source / arm / continuous / delay fields from that word.
- Qualifies a chosen sync source: external 1PPS, internal periodic counter or software one-shot.
- Emits an aligned, delayed, fixed-width sync pulse to the correlator datapath.

Parameters:
- PERIOD, 16777216, internal sync period in user_clk cycles (≥2).
- PULSE_LEN, 4, sync_out high width in cycles (≥1).
- SYNC_STAGES, 2, synchronizer flops on ext_sync (≥2).

Ports:
- user_clk  in  1  sole clock.
- user_rst_n  in  1  asynchronous active-low reset.
- sync_sel  in  32  register word from upstream, treated as quasi-static:
  - [1:0] src: 0 off, 1 ext, 2 int, 3 sw.
  - [4] arm.
  - [5] cont.
  - [31:16] delay.
  - Other bits ignored.
- ext_sync  in  1  asynchronous external 1PPS.
- sync_out  out  1  generated sync pulse.
- armed  out  1  high while in ARMED.
- busy  out  1  high while in DELAY or PULSE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - sync_out=armed=busy=0.
  - int counter=0, delay counter=0, pulse counter=0.
  - Synchronizer flops=0.
  - arm_q=1, so an arm bit already set at reset release does not arm.
- ext path:
  - SYNC_STAGES-flop synchronizer, then rising-edge detect.
  - ext_evt is a 1-cycle pulse SYNC_STAGES+1 cycles after ext_sync rises.
  - Level held high produces exactly one event.
- int path:
  - Counter runs 0..PERIOD-1 and wraps.
  - int_evt=1 when counter==PERIOD-1.
  - Counter clears to 0 on any src change (src_q != src).
- arm_rise = sync_sel[4] & ~arm_q; arm_q registered every cycle.
- sel_evt = ext_evt (src=1), int_evt (src=2), 1 (src=3), 0 (src=0).
- FSM:
  - IDLE: arm_rise & src!=0 -> ARMED.
  - ARMED: sel_evt -> latch D=delay.
    - D==0 -> PULSE.
    - D>0 -> DELAY.
  - DELAY: delay counter counts D cycles, then -> PULSE.
  - PULSE: sync_out=1 for exactly PULSE_LEN cycles.
    - Then cont=1 and src∈{1,2} -> ARMED.
    - Otherwise -> IDLE.
    - src=3 is always one-shot.
- Latency: sel_evt seen in ARMED at cycle N -> sync_out rises at cycle N+1+D.
  - src=3: arm_rise at cycle A -> ARMED at A+1 -> sync_out rises at A+2+D.
- Boundary conditions:
  - src becomes 0 in any state -> IDLE next cycle; sync_out/armed/busy 0 that same next cycle; pulse truncated.
  - src change to non-zero outside IDLE: no abort. Current delay/pulse completes; the next ARMED uses the new src.
  - Events in IDLE, DELAY or PULSE are ignored; no queueing.
  - arm_rise outside IDLE is ignored.
  - delay=0xFFFF gives 65535 cycles of DELAY.
  - delay is latched at the event, so later register writes do not affect the pending pulse.
  - int_evt coinciding with the ARMED entry cycle is not taken; it is taken from the cycle after entry.
- All outputs registered; no combinational input-to-output paths.

Optional Feature:
- Macro SYNC_SEL_GEN_CNT_EN.
- Defined:
  - Adds output sync_cnt [31:0]: count of sync_out rising edges, reset 0, wraps 0xFFFFFFFF->0.
  - Adds output miss_cnt [15:0]: count of sel_evt (src 1/2) arriving in DELAY or PULSE, saturating at 0xFFFF.
  - Both counters clear when arm_rise is accepted.
- Undefined: neither port nor counter exists; all other behaviour identical.

Test Plan:
- Reset release with sync_sel=0x00000011 -> no arming (arm_q=1); clear then set bit 4 -> armed=1 one cycle after the rising edge.
- src=1, delay=0, arm; ext_sync rises at cycle T -> sync_out high cycles T+SYNC_STAGES+2 .. T+SYNC_STAGES+5 (PULSE_LEN=4), then IDLE, armed=0.
- PERIOD=16, src=2, cont=1, delay=3 -> sync_out rises every 16 cycles, 4 cycles after each int_evt, armed re-asserts between pulses.
- src=3, delay=5, arm rising at cycle A -> one sync_out pulse rising at A+7; arm held high causes no second pulse.
- Mid-DELAY, write src=0 -> state IDLE next cycle, sync_out never asserts, busy=0.
- CNT_EN, src=1, cont=1, delay=100, two ext edges 50 cycles apart -> sync_cnt=1, miss_cnt=1.
